mem_sram_ctrl: RTL
==================

// Module: mem_sram_ctrl
// PURPOSE
//  MEM-stage controller; consumes the EXE->MEM load/store interface (mem_r, mem_w, ALU address, store data).
//  Each 32-bit access becomes two 16-bit accesses to an external asynchronous SRAM.
//  Holds ready low (pipeline freeze) until the access completes.
// PARAMETERS
//  ADDR_BASE    1024  byte address mapped to SRAM word 0
//  SRAM_AW      18    SRAM address width (16-bit locations)
//  WAIT_CYCLES  2     cycles per 16-bit phase; legal range 2..15
// PORTS
//  clk          in   1   single clock; all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  mem_r        in   1   load request, held stable while ready=0
//  mem_w        in   1   store request, held stable while ready=0
//  addr         in   32  byte address from ALU result, word aligned
//  wdata        in   32  store data (val_rm)
//  rdata        out  32  load data, valid in the ready=1 completion cycle
//  ready        out  1   0 = freeze pipeline; 1 = no access pending or access done
//  sram_addr    out  SRAM_AW  SRAM location
//  sram_dq_out  out  16  write data to pad
//  sram_dq_oe   out  1   1 = drive sram_dq_out onto the bus
//  sram_dq_in   in   16  read data from pad
//  sram_we_n    out  1   active-low write strobe
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, cnt=0, rdata=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1.
//  ready is combinational: (state==IDLE && !(mem_r|mem_w)) || state==DONE. All SRAM outputs are registered.
//  Address: word = (addr-ADDR_BASE)>>2, truncated to SRAM_AW-1 bits.
//   LO phase uses {word,0}; HI phase uses {word,1}. addr[1:0] is ignored.
//  Priority: mem_w has priority over mem_r when both are 1; the access is then a store.
//  FSM:
//   IDLE: no request -> stay in IDLE; request -> go to LO, cnt=0, latch op/addr/wdata.
//   LO:   sram_addr={word,0}. Store: dq_oe=1, dq_out=wdata[15:0].
//         cnt counts 0..WAIT_CYCLES-1.
//         On the last count: load samples sram_dq_in into rdata[15:0]; go to HI.
//   HI:   same as LO with {word,1} and wdata/rdata[31:16]; on the last count go to DONE.
//   DONE: ready=1 for exactly one cycle; dq_oe=0, we_n=1; go to IDLE.
//  Store strobe: we_n=0 on every cycle of a phase except the last.
//   Address and data stay stable through the last cycle (hold time).
//  Latency with request first seen in cycle 0: ready=1 in cycle 2*WAIT_CYCLES+1.
//   WAIT_CYCLES=2 gives 6 frozen+done cycles total.
//  Next request: taken in IDLE on the cycle after DONE; there is no back-to-back overlap.
//  Request dropped mid-access: the latched access completes normally; inputs are ignored after IDLE.
//  Reset mid-access: abort immediately to reset values; the partial SRAM write is not undone.
//  rdata keeps its value until the next load completes; stores do not modify it.
//  Loads keep sram_dq_oe=0 and sram_we_n=1 throughout.
// STRUCTURE
//  Shared defines/package: FSM state encodings (IDLE, LO, HI, DONE) and a 2-bit phase type.
//  Sub-module sram_wait_cnt: 4-bit counter with clear and terminal-count (cnt==WAIT_CYCLES-1).
//  All other logic stays in this module.
// TESTING
//  1 Reset, no request:
//    -> ready=1, we_n=1, dq_oe=0, rdata=0.
//  2 Store 0xDEADBEEF @1024 (W=2):
//    -> addr 0 / 0xBEEF, then addr 1 / 0xDEAD, with we_n low 1 cycle in each phase.
//    -> ready=0 for cycles 0..4, ready=1 in cycle 5.
//  3 Load @1024 after test 2, SRAM model returns the stored data:
//    -> rdata=0xDEADBEEF when ready=1; we_n stays 1.
//  4 Store @1028 with mem_r=mem_w=1:
//    -> treated as a store to SRAM addr 2 and 3.
//  5 Assert rst=0 in the HI phase of a store:
//    -> outputs return to reset values in the same cycle; the next request restarts at LO.
//  6 Back-to-back loads @1024 then @1032, SRAM model varies dq_in:
//    -> second access starts the cycle after DONE; addresses 0,1 then 4,5; each rdata is correct.

Source files
------------

// File: rtl/mem_sram_ctrl_pkg.sv
// Shared types for the MEM-stage SRAM controller.
// Holds the FSM state encoding, the phase type and the counter width.
package mem_sram_ctrl_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        PH_LO = 2'd0,
        PH_HI = 2'd1
    } phase_t;

endpackage

// File: rtl/sram_wait_cnt.sv
// Per-phase wait counter for the SRAM controller.
// Ports: clk, rst (async active-low), clr, en -> cnt, tc (cnt==WAIT_CYCLES-1).
module sram_wait_cnt
    import mem_sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_sram_ctrl.sv
// MEM-stage controller: one 32-bit load/store becomes two 16-bit SRAM accesses.
// Ports: clk, rst, mem_r, mem_w, addr, wdata -> rdata, ready; SRAM: addr/dq_out/dq_oe/dq_in/we_n.
module mem_sram_ctrl
    import mem_sram_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_BASE   = 1024,
    parameter int          SRAM_AW     = 18,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mem_r,
    input  logic               mem_w,
    input  logic [31:0]        addr,
    input  logic [31:0]        wdata,
    output logic [31:0]        rdata,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n
);

    localparam int WW = SRAM_AW - 1;
    localparam logic [CNT_W-1:0] CNT_PEN = CNT_W'(WAIT_CYCLES - 2);

    state_t           state;
    logic             op_w;
    logic [WW-1:0]    word;
    logic [15:0]      wdata_hi;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             busy;
    logic             req;
    logic [31:0]      off;
    logic [WW-1:0]    req_word;
    logic             unused_off;

    assign req        = mem_r | mem_w;
    assign off        = addr - 32'(ADDR_BASE);
    assign req_word   = off[WW+1:2];
    assign unused_off = ^{off[31:WW+2], off[1:0]};
    assign busy       = (state == LO) || (state == HI);
    assign ready      = ((state == IDLE) && !req) || (state == DONE);

    sram_wait_cnt #(
        .WAIT_CYCLES(WAIT_CYCLES)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!busy || tc),
        .en  (busy),
        .cnt (cnt),
        .tc  (tc)
    );

    // SRAM pins are loaded one cycle ahead so that they are registered
    // outputs; we_n for the next cycle is high when that cycle is the
    // last of its phase (cnt about to reach WAIT_CYCLES-1).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            op_w        <= 1'b0;
            word        <= '0;
            wdata_hi    <= '0;
            rdata       <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        state       <= LO;
                        op_w        <= mem_w;
                        word        <= req_word;
                        wdata_hi    <= wdata[31:16];
                        sram_addr   <= {req_word, 1'b0};
                        sram_dq_out <= wdata[15:0];
                        sram_dq_oe  <= mem_w;
                        sram_we_n   <= !mem_w;
                    end
                end
                LO: begin
                    if (tc) begin
                        if (!op_w) rdata[15:0] <= sram_dq_in;
                        state       <= HI;
                        sram_addr   <= {word, 1'b1};
                        sram_dq_out <= wdata_hi;
                        sram_we_n   <= !op_w;
                    end else begin
                        sram_we_n <= !op_w || (cnt == CNT_PEN);
                    end
                end
                HI: begin
                    if (tc) begin
                        if (!op_w) rdata[31:16] <= sram_dq_in;
                        state      <= DONE;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        sram_we_n <= !op_w || (cnt == CNT_PEN);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
